// File: rtl/counter_rr_scheduler.sv
// counter_rr_scheduler
// One prescaled up-counter shared by NUM_REQ requesters. An idle scheduler
// grants the first requester found scanning from a round-robin pointer. It
// latches that requester's target and counts 0..target, advancing one step
// per prescaled tick. When the target is reached it pulses done on the
// owner's bit. If the owner drops its request before then, it pulses abort.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   req_i     level request per requester
//   target_i  per-requester target, slice i = target_i[i*CNT_W +: CNT_W]
//   grant_o   one-hot owner of the counter, 0 when idle
//   count_o   current shared counter value
//   done_o    one-cycle pulse on the owner's bit when its target is reached
//   abort_o   one-cycle pulse when the owner drops req before its target
//   busy_o    high while counting and in the done cycle
module counter_rr_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TICK_DIV = 1500000,
  parameter int unsigned DIV_W    = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] target_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [CNT_W-1:0]         count_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     abort_o,
  output logic                     busy_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [DIV_W-1:0] DivMax = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e               state_q, state_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [DIV_W-1:0]     presc_q, presc_d;
  logic [CNT_W-1:0]     tgt_q, tgt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 abort_q, abort_d;
  logic                 busy_q, busy_d;

  // Round-robin pick
  logic                 win_found;
  logic [PtrW-1:0]      win_idx;
  logic [PtrW-1:0]      cand;
  logic [PtrW-1:0]      ptr_next;
  logic [NUM_REQ-1:0]   grant_win;
  logic [CNT_W-1:0]     tgt_win;

  logic                 tick;
  logic                 req_owner;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    tgt_win = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (win_idx == PtrW'(j)) begin
        tgt_win = target_i[j*CNT_W +: CNT_W];
      end
    end
  end

  assign grant_win = NUM_REQ'(1) << win_idx;
  assign ptr_next  = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + PtrW'(1);
  assign tick      = (presc_q == DivMax);
  // Only the owner's request matters once counting.
  assign req_owner = |(req_i & grant_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    presc_d = presc_q;
    tgt_d   = tgt_q;
    grant_d = grant_q;
    count_d = count_q;
    done_d  = '0;
    abort_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StCount;
          grant_d = grant_win;
          tgt_d   = tgt_win;
          count_d = '0;
          presc_d = '0;
          ptr_d   = ptr_next;
        end
      end
      StCount: begin
        // Abort wins over a coincident tick.
        if (!req_owner) begin
          state_d = StIdle;
          grant_d = '0;
          count_d = '0;
          presc_d = '0;
          abort_d = 1'b1;
        end else begin
          presc_d = tick ? '0 : presc_q + DIV_W'(1);
          if (tick) begin
            if (count_q == tgt_q) begin
              state_d = StDone;
              done_d  = grant_q;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = '0;
        count_d = '0;
        presc_d = '0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        count_d = '0;
        presc_d = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      presc_q <= '0;
      tgt_q   <= '0;
      grant_q <= '0;
      count_q <= '0;
      done_q  <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      presc_q <= presc_d;
      tgt_q   <= tgt_d;
      grant_q <= grant_d;
      count_q <= count_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o = grant_q;
  assign count_o = count_q;
  assign done_o  = done_q;
  assign abort_o = abort_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Directed bench for counter_rr_scheduler with a short prescaler (TICK_DIV=4).
module tb_counter_rr_scheduler;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DIV_W    = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] target;
  logic [NUM_REQ-1:0]       grant;
  logic [CNT_W-1:0]         count;
  logic [NUM_REQ-1:0]       done;
  logic                     abort;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  counter_rr_scheduler #(
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W),
    .TICK_DIV(TICK_DIV),
    .DIV_W   (DIV_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .target_i(target),
    .grant_o (grant),
    .count_o (count),
    .done_o  (done),
    .abort_o (abort),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] c,
                           input logic [3:0] d, input logic a, input logic b);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_count"}, 32'(count), 32'(c));
    check({tag, "_done"},  32'(done),  32'(d));
    check({tag, "_abort"}, 32'(abort), 32'(a));
    check({tag, "_busy"},  32'(busy),  32'(b));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Invariants checked every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_onehot", 32'($onehot0(grant)), 32'd1);
      check("inv_done_abort", 32'(|done && abort), 32'd0);
      check("inv_done_in_grant", 32'(done & ~grant), 32'd0);
    end
  end

  initial begin
    logic [3:0] exp_g;
    rst    = 1'b1;
    req    = '0;
    target = '0;
    step(2);
    check_out("reset", 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    step(1);
    check_out("idle_hold", 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0);

    // 1: target 3, count steps every 4 clocks, done 16 clocks after grant
    target = 16'h0003;
    req    = 4'b0001;
    step(1);
    check_out("t1_grant", 4'b0001, 4'd0, 4'b0000, 1'b0, 1'b1);
    step(4);
    check("t1_count1", 32'(count), 32'd1);
    step(4);
    check("t1_count2", 32'(count), 32'd2);
    step(4);
    check("t1_count3", 32'(count), 32'd3);
    step(3);
    check_out("t1_pre_done", 4'b0001, 4'd3, 4'b0000, 1'b0, 1'b1);
    step(1);
    check_out("t1_done", 4'b0001, 4'd3, 4'b0001, 1'b0, 1'b1);
    req = 4'b0000;
    step(1);
    check_out("t1_idle", 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0);

    // 2: target 0 still takes one tick
    target = 16'h0000;
    req    = 4'b0001;
    step(1);
    check_out("t2_grant", 4'b0001, 4'd0, 4'b0000, 1'b0, 1'b1);
    step(3);
    check_out("t2_pre_done", 4'b0001, 4'd0, 4'b0000, 1'b0, 1'b1);
    step(1);
    check_out("t2_done", 4'b0001, 4'd0, 4'b0001, 1'b0, 1'b1);
    req = 4'b0000;
    step(1);
    check_out("t2_idle", 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0);

    // 3: all request, round-robin order from pointer 0
    do_reset();
    target = 16'h1111;
    req    = 4'b1111;
    exp_g  = 4'b0001;
    step(1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_grant%0d", k), 32'(grant), 32'(exp_g));
      if (k < 4) begin
        step(8);
        check_out($sformatf("t3_done%0d", k), exp_g, 4'd1, exp_g, 1'b0, 1'b1);
        step(1);
        check_out($sformatf("t3_gap%0d", k), 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0);
        step(1);
        exp_g = {exp_g[2:0], exp_g[3]};
      end
    end
    req = 4'b0000;
    step(1);
    check_out("t3_abort", 4'b0000, 4'd0, 4'b0000, 1'b1, 1'b0);
    step(1);
    check("t3_abort_clear", 32'(abort), 32'd0);

    // 4: owner 2 drops at count 2, requester 3 pending (pointer is 1 here)
    target = 16'h1500;
    req    = 4'b1100;
    step(1);
    check("t4_grant2", 32'(grant), 32'h4);
    step(8);
    check("t4_count2", 32'(count), 32'd2);
    req = 4'b1000;
    step(1);
    check_out("t4_abort", 4'b0000, 4'd0, 4'b0000, 1'b1, 1'b0);
    step(1);
    check_out("t4_grant3", 4'b1000, 4'd0, 4'b0000, 1'b0, 1'b1);
    step(8);
    check_out("t4_done3", 4'b1000, 4'd1, 4'b1000, 1'b0, 1'b1);
    req = 4'b0000;
    step(1);
    check_out("t4_idle", 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0);

    // 5: target change during counting is ignored
    target = 16'h0005;
    req    = 4'b0001;
    step(1);
    check("t5_grant", 32'(grant), 32'h1);
    step(2);
    target = 16'h0001;
    step(18);
    check_out("t5_count5", 4'b0001, 4'd5, 4'b0000, 1'b0, 1'b1);
    step(3);
    check("t5_pre_done", 32'(done), 32'd0);
    step(1);
    check_out("t5_done", 4'b0001, 4'd5, 4'b0001, 1'b0, 1'b1);
    req = 4'b0000;
    step(1);
    check_out("t5_idle", 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0);

    // 6: reset mid-count clears immediately, pointer returns to 0
    target = 16'h0003;
    req    = 4'b0001;
    step(1);
    check("t6_grant", 32'(grant), 32'h1);
    step(8);
    check_out("t6_count2", 4'b0001, 4'd2, 4'b0000, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_out("t6_async_rst", 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0);
    target = 16'h0011;
    req    = 4'b0011;
    step(1);
    rst = 1'b0;
    step(1);
    check_out("t6_after_rst", 4'b0001, 4'd0, 4'b0000, 1'b0, 1'b1);
    req = 4'b0000;
    step(1);
    check_out("t6_abort", 4'b0000, 4'd0, 4'b0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
